// File: rtl/battery_pkg.sv
// Shared battery definitions: level width/limit and mode encodings, common to
// battery_level_counter and state_indicator.
package battery_pkg;

  localparam int unsigned BATT_W   = 5;
  localparam int unsigned BATT_MAX = 30;

  localparam logic [1:0] MODE_DISCHARGE = 2'b00;
  localparam logic [1:0] MODE_CHARGE    = 2'b01;
  localparam logic [1:0] MODE_DEPLETED  = 2'b10;

  // State encodings double as the mode output, so mode needs no decode.
  typedef enum logic [1:0] {
    StDischarge = MODE_DISCHARGE,
    StCharge    = MODE_CHARGE,
    StDepleted  = MODE_DEPLETED
  } batt_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Counts tick strobes up to a runtime limit and pulses expire_o on the strobe
// that completes the count; sync clear discards any partial count.
module tick_prescaler #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_i,
  input  logic            clear_i,
  input  logic [CntW-1:0] limit_i,
  output logic            expire_o
);

  logic [CntW-1:0] count_q, count_d;
  logic [CntW:0]   count_inc;

  assign count_inc = {1'b0, count_q} + (CntW + 1)'(1);

  // >= keeps the count bounded if the limit shrinks mid-count.
  assign expire_o = tick_i & ~clear_i & (count_inc >= {1'b0, limit_i});

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = expire_o ? '0 : count_inc[CntW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/battery_level_counter.sv
// Battery level source: drains on prescaled ticks, refills while charging,
// saturating at 0 and MAX_LEVEL; feeds state_indicator.battery.
module battery_level_counter
  import battery_pkg::*;
#(
  parameter int unsigned LEVEL_W      = BATT_W,
  parameter int unsigned MAX_LEVEL    = BATT_MAX,
  parameter int unsigned DRAIN_TICKS  = 8,
  parameter int unsigned CHARGE_TICKS = 4,
  parameter int unsigned CHARGE_STEP  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               charge_req,
  input  logic               heavy_load,
  output logic [LEVEL_W-1:0] battery,
  output logic [1:0]         mode,
  output logic               full,
  output logic               empty
);

  localparam int unsigned CntW = $clog2(max_u(DRAIN_TICKS, CHARGE_TICKS) + 1);

  localparam logic [CntW-1:0]    DrainLim  = CntW'(DRAIN_TICKS);
  localparam logic [CntW-1:0]    HeavyLim  = CntW'(DRAIN_TICKS / 2);
  localparam logic [CntW-1:0]    ChargeLim = CntW'(CHARGE_TICKS);
  localparam logic [LEVEL_W-1:0] LevelMax  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W:0]   SumMax    = (LEVEL_W + 1)'(MAX_LEVEL);
  localparam logic [LEVEL_W:0]   StepExt   = (LEVEL_W + 1)'(CHARGE_STEP);

  batt_state_e        state_q, state_d;
  logic [LEVEL_W-1:0] battery_q, battery_d;
  logic               full_q, empty_q;
  logic               pre_clear, pre_expire;
  logic [CntW-1:0]    pre_limit;
  logic [LEVEL_W:0]   charge_sum;

  tick_prescaler #(
    .CntW (CntW)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick),
    .clear_i  (pre_clear),
    .limit_i  (pre_limit),
    .expire_o (pre_expire)
  );

  always_comb begin
    state_d    = state_q;
    battery_d  = battery_q;
    pre_clear  = 1'b0;
    pre_limit  = DrainLim;
    charge_sum = {1'b0, battery_q} + StepExt;
    case (state_q)
      StDischarge: begin
        pre_limit = heavy_load ? HeavyLim : DrainLim;
        // Clearing the prescaler also masks a same-cycle expiry: charge wins.
        if (charge_req) begin
          state_d   = StCharge;
          pre_clear = 1'b1;
        end else if (pre_expire) begin
          battery_d = (battery_q == '0) ? '0 : battery_q - LEVEL_W'(1);
          if (battery_d == '0) begin
            state_d = StDepleted;
          end
        end
      end
      StCharge: begin
        pre_limit = ChargeLim;
        if (!charge_req) begin
          state_d   = StDischarge;
          pre_clear = 1'b1;
        end else if (pre_expire) begin
          battery_d = (charge_sum > SumMax) ? LevelMax : charge_sum[LEVEL_W-1:0];
        end
      end
      StDepleted: begin
        pre_clear = 1'b1;
        battery_d = '0;
        if (charge_req) begin
          state_d = StCharge;
        end
      end
      default: begin
        state_d   = StDischarge;
        pre_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StDischarge;
      battery_q <= LevelMax;
      full_q    <= 1'b1;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      battery_q <= battery_d;
      full_q    <= (battery_d == LevelMax);
      empty_q   <= (battery_d == '0);
    end
  end

  assign battery = battery_q;
  assign mode    = state_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: tb/tb_battery_level_counter.sv
// Scoreboard bench for battery_level_counter: directed scenarios followed by
// randomized traffic, checked against a behavioural level model.
module tb_battery_level_counter;

  localparam int DRAIN  = 4;
  localparam int CHARGE = 2;
  localparam int STEP   = 2;
  localparam int MAXL   = 30;

  typedef struct packed {
    logic [4:0] batt;
    logic [1:0] mode;
    logic       full;
    logic       empty;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       charge_req = 1'b0;
  logic       heavy_load = 1'b0;
  logic [4:0] battery;
  logic [1:0] mode;
  logic       full;
  logic       empty;

  int checks = 0;
  int failures = 0;

  exp_t sb[$];

  // Reference model: level, mode (0 discharge, 1 charge, 2 depleted), ticks seen.
  int m_batt;
  int m_mode;
  int m_cnt;

  battery_level_counter #(
    .LEVEL_W      (5),
    .MAX_LEVEL    (MAXL),
    .DRAIN_TICKS  (DRAIN),
    .CHARGE_TICKS (CHARGE),
    .CHARGE_STEP  (STEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .charge_req (charge_req),
    .heavy_load (heavy_load),
    .battery    (battery),
    .mode       (mode),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_batt = MAXL;
    m_mode = 0;
    m_cnt  = 0;
  endtask

  task automatic model_step(input bit t, input bit c, input bit h);
    int lim;
    case (m_mode)
      0: begin
        if (c) begin
          m_mode = 1;
          m_cnt  = 0;
        end else if (t) begin
          lim = h ? DRAIN / 2 : DRAIN;
          m_cnt++;
          if (m_cnt >= lim) begin
            m_cnt  = 0;
            m_batt = (m_batt > 0) ? m_batt - 1 : 0;
            if (m_batt == 0) m_mode = 2;
          end
        end
      end
      1: begin
        if (!c) begin
          m_mode = 0;
          m_cnt  = 0;
        end else if (t) begin
          m_cnt++;
          if (m_cnt >= CHARGE) begin
            m_cnt  = 0;
            m_batt = (m_batt + STEP > MAXL) ? MAXL : m_batt + STEP;
          end
        end
      end
      default: begin
        m_batt = 0;
        if (c) begin
          m_mode = 1;
          m_cnt  = 0;
        end
      end
    endcase
  endtask

  // One clock: drive, predict, then resume 2ns after the edge.
  task automatic cyc(input bit t, input bit c, input bit h);
    exp_t e;
    tick       = t;
    charge_req = c;
    heavy_load = h;
    model_step(t, c, h);
    e.batt  = 5'(m_batt);
    e.mode  = 2'(m_mode);
    e.full  = (m_batt == MAXL);
    e.empty = (m_batt == 0);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n, input bit c, input bit h);
    repeat (n) begin
      cyc(1'b1, c, h);
      cyc(1'b0, c, h);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    tick       = 1'b0;
    charge_req = 1'b0;
    heavy_load = 1'b0;
    #1;
    chk("rst_batt", int'(battery), MAXL);
    chk("rst_mode", int'(mode), 0);
    chk("rst_full", int'(full), 1);
    chk("rst_empty", int'(empty), 0);
    model_reset();
    @(posedge clk);
    #2;
    chk("rst_hold_batt", int'(battery), MAXL);
    rst_n = 1'b1;
  endtask

  // Monitor: the DUT presents a new output every clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_batt", int'(battery), int'(e.batt));
        chk("sb_mode", int'(mode), int'(e.mode));
        chk("sb_full", int'(full), int'(e.full));
        chk("sb_empty", int'(empty), int'(e.empty));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit t, c, h;
    model_reset();
    @(posedge clk);
    #2;
    do_reset();

    // Normal drain, then idle cycles must not move the level.
    ticks(8, 1'b0, 1'b0);
    chk("t2_batt", int'(battery), 28);
    chk("t2_full", int'(full), 0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    chk("t2_idle_batt", int'(battery), 28);

    // Charge request on the expiring drain tick: no decrement, count restarts.
    ticks(3, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t5_batt", int'(battery), 28);
    chk("t5_mode", int'(mode), 1);
    ticks(1, 1'b1, 1'b0);
    chk("t5_restart_batt", int'(battery), 28);
    ticks(1, 1'b1, 1'b0);
    chk("t5_step_batt", int'(battery), 30);
    cyc(1'b0, 1'b0, 1'b0);
    ticks(12, 1'b0, 1'b0);
    chk("t4_pre_batt", int'(battery), 27);

    // Charge saturation at MAX_LEVEL.
    cyc(1'b0, 1'b1, 1'b0);
    ticks(2, 1'b1, 1'b0);
    chk("t4_batt29", int'(battery), 29);
    ticks(2, 1'b1, 1'b0);
    chk("t4_batt30", int'(battery), 30);
    chk("t4_full", int'(full), 1);
    chk("t4_mode", int'(mode), 1);
    ticks(2, 1'b1, 1'b0);
    chk("t4_hold", int'(battery), 30);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t4_mode_dis", int'(mode), 0);

    // Heavy drain to empty.
    ticks(54, 1'b0, 1'b1);
    chk("t3_batt3", int'(battery), 3);
    ticks(2, 1'b0, 1'b1);
    chk("t3_batt2", int'(battery), 2);
    ticks(2, 1'b0, 1'b1);
    chk("t3_batt1", int'(battery), 1);
    ticks(2, 1'b0, 1'b1);
    chk("t3_batt0", int'(battery), 0);
    chk("t3_mode", int'(mode), 2);
    chk("t3_empty", int'(empty), 1);
    ticks(4, 1'b0, 1'b1);
    chk("t3_stay0", int'(battery), 0);

    // Reset in the middle of charging.
    cyc(1'b0, 1'b1, 1'b0);
    ticks(12, 1'b1, 1'b0);
    chk("t6_batt12", int'(battery), 12);
    ticks(1, 1'b1, 1'b0);
    do_reset();
    ticks(3, 1'b0, 1'b0);
    chk("t6_no_early_drain", int'(battery), 30);
    ticks(1, 1'b0, 1'b0);
    chk("t6_first_drain", int'(battery), 29);

    // Randomized traffic.
    c = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        c = 1'b0;
      end
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) c = ~c;
      h = ($urandom_range(0, 3) == 0) ? ~heavy_load : heavy_load;
      cyc(t, c, h);
    end

    @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
